env_scheduler: RTL and testbench
================================

ENV_SCHEDULER -- requirements
Module: env_scheduler

Interface
REQ-001 Parameter NUM_BANDS, default 16, number of vocoder bands sharing one envelope filter; legal range 2..64.
REQ-002 Parameter WIDTH, default 24, signed sample width in bits.
REQ-003 clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 sample_valid_in  input  1  one-cycle audio-rate strobe; band_samples_in valid this cycle.
REQ-006 band_samples_in  input  NUM_BANDS*WIDTH  signed band-filter outputs; band b at bits [b*WIDTH +: WIDTH].
REQ-007 filt_valid_out  output  1  request to shared filter; the sample is offered.
REQ-008 filt_band_out  output  clog2(NUM_BANDS)  band index selecting the filter's coefficient/state bank.
REQ-009 filt_sample_out  output  WIDTH  rectified (non-negative) sample to the filter.
REQ-010 filt_ready_in  input  1  filter accepts the request this cycle.
REQ-011 filt_done_in  input  1  one-cycle pulse; filt_sample_in holds the result.
REQ-012 filt_sample_in  input  WIDTH  signed filtered envelope.
REQ-013 env_out  output  NUM_BANDS*WIDTH  registered envelope per band, same packing as band_samples_in.
REQ-014 env_valid_out  output  1  one-cycle pulse: all bands updated for this frame.
REQ-015 busy_out  output  1  high in any state other than IDLE.
REQ-016 overrun_out  output  1  sticky dropped-strobe flag (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: on sample_valid_in, latch all of band_samples_in into a frame buffer, set index to 0, go to ISSUE.
REQ-019 ISSUE: filt_valid_out=1, filt_band_out=index, filt_sample_out=|buffer[index]|; hold all three stable until filt_ready_in=1, then go to WAIT.
REQ-020 WAIT: filt_valid_out=0; on filt_done_in, write filt_sample_in to env_out[index]; if index=NUM_BANDS-1 go to DONE, else increment index and go to ISSUE.
REQ-021 DONE: env_valid_out=1 for exactly one cycle, then go to IDLE.
REQ-022 Rectification SHALL be two's-complement absolute value, saturating: the most negative value (-2^(WIDTH-1)) maps to 2^(WIDTH-1)-1.
REQ-023 Latency SHALL be as follows, with filt_ready_in tied high and filt_done_in arriving one cycle after acceptance:
- band k is issued in cycle 1+2k after the strobe (strobe = cycle 0);
- env_valid_out is high in cycle 2*NUM_BANDS+1.
REQ-024 sample_valid_in while busy_out=1 (including DONE) SHALL be ignored; the frame buffer and the sequence are unaffected.
REQ-025 filt_done_in outside WAIT SHALL be ignored; filt_done_in in the same cycle as the ISSUE acceptance SHALL be ignored.
REQ-026 env_out entries not yet rewritten SHALL hold their previous-frame values during a frame.

Reset
REQ-027 rst_in SHALL force IDLE, index=0, env_out=0, frame buffer=0, filt_valid_out=0, env_valid_out=0, busy_out=0, overrun_out=0.
REQ-028 Reset mid-frame SHALL abort the frame without asserting env_valid_out; the first strobe after reset deasserts starts a fresh frame.

Configuration
REQ-029 Macro ENV_SCHEDULER_OVERRUN_EN. When defined: overrun_out sets on any strobe dropped per REQ-024 and clears only on rst_in. When undefined: overrun_out is constant 0 and no overrun logic is built.

Verification
REQ-030 NUM_BANDS=4, ready high, done 1 cycle after accept; strobe with bands {100,-200,300,-400}, filter echoes its input -> filt_band_out 0,1,2,3 in cycles 1,3,5,7; env_out={100,200,300,400}; env_valid_out in cycle 9 only.
REQ-031 Band sample -8388608 (WIDTH=24) -> filt_sample_out=8388607.
REQ-032 filt_ready_in low for 5 cycles during ISSUE -> filt_valid_out, filt_band_out and filt_sample_out stay stable; the sequence resumes on ready; env_valid_out is delayed by 5 cycles.
REQ-033 Second strobe in cycle 3 of a frame -> ignored, frame completes with the original data; overrun_out=1 with the macro defined, 0 without.
REQ-034 rst_in asserted in cycle 4 of a frame -> no env_valid_out, env_out=0, busy_out=0 the next cycle; a new strobe completes a normal frame.
REQ-035 Spurious filt_done_in in IDLE and in ISSUE -> env_out unchanged, index unchanged.

Source files
------------

// File: rtl/env_scheduler.sv
// Time-multiplexes one shared envelope filter across NUM_BANDS vocoder bands, one band per request/response.
// Optional sticky dropped-strobe flag: define ENV_SCHEDULER_OVERRUN_EN.
module env_scheduler #(
  parameter int NUM_BANDS = 16,
  parameter int WIDTH     = 24
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          sample_valid_in,
  input  logic [NUM_BANDS*WIDTH-1:0]    band_samples_in,
  output logic                          filt_valid_out,
  output logic [$clog2(NUM_BANDS)-1:0]  filt_band_out,
  output logic [WIDTH-1:0]              filt_sample_out,
  input  logic                          filt_ready_in,
  input  logic                          filt_done_in,
  input  logic [WIDTH-1:0]              filt_sample_in,
  output logic [NUM_BANDS*WIDTH-1:0]    env_out,
  output logic                          env_valid_out,
  output logic                          busy_out,
  output logic                          overrun_out
);

  localparam int IW = $clog2(NUM_BANDS);
  localparam logic [IW-1:0]    LAST     = IW'(NUM_BANDS - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM_BANDS*WIDTH-1:0]   buf_q, buf_d;
  logic [NUM_BANDS*WIDTH-1:0]   env_q, env_d;
  logic                         filt_valid_q, filt_valid_d;
  logic [WIDTH-1:0]             filt_sample_q, filt_sample_d;
  logic                         env_valid_q, env_valid_d;
  logic                         busy_q, busy_d;

  // Saturating magnitude: the most negative code has no positive twin.
  function automatic logic [WIDTH-1:0] rectify(input logic [WIDTH-1:0] x);
    if (x == MOST_NEG) return MAX_POS;
    if (x[WIDTH-1])    return (~x) + ONE;
    return x;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    env_d   = env_q;
    unique case (state_q)
      IDLE: if (sample_valid_in) begin
        buf_d   = band_samples_in;
        idx_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: if (filt_ready_in) state_d = WAIT;
      WAIT: if (filt_done_in) begin
        env_d[idx_q*WIDTH +: WIDTH] = filt_sample_in;
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they are registered yet cycle-aligned with it.
    filt_valid_d  = (state_d == ISSUE);
    filt_sample_d = rectify(buf_d[idx_d*WIDTH +: WIDTH]);
    env_valid_d   = (state_d == DONE);
    busy_d        = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      // NOTE: the frame buffer and envelope storage are flops, not RAM, so clearing them on reset is legal.
      buf_q         <= '0;
      env_q         <= '0;
      filt_valid_q  <= 1'b0;
      filt_sample_q <= '0;
      env_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      env_q         <= env_d;
      filt_valid_q  <= filt_valid_d;
      filt_sample_q <= filt_sample_d;
      env_valid_q   <= env_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign filt_valid_out  = filt_valid_q;
  assign filt_band_out   = idx_q;
  assign filt_sample_out = filt_sample_q;
  assign env_out         = env_q;
  assign env_valid_out   = env_valid_q;
  assign busy_out        = busy_q;

`ifdef ENV_SCHEDULER_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb overrun_d = overrun_q | (sample_valid_in && (state_q != IDLE));

  always_ff @(posedge clk_in) begin
    if (rst_in) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun_out = overrun_q;
`else
  assign overrun_out = 1'b0;
`endif

endmodule

// File: tb/tb_env_scheduler.sv
// Directed bench for env_scheduler (4 bands x 24 bits) with an echoing filter model.
module tb_env_scheduler;

  localparam int NB  = 4;
  localparam int W   = 24;
  localparam int TOT = NB * W;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  sample_valid_in;
  logic [TOT-1:0]        band_samples_in;
  logic                  filt_valid_out;
  logic [1:0]            filt_band_out;
  logic [W-1:0]          filt_sample_out;
  logic                  filt_ready_in;
  logic                  filt_done_in;
  logic [W-1:0]          filt_sample_in;
  logic [TOT-1:0]        env_out;
  logic                  env_valid_out;
  logic                  busy_out;
  logic                  overrun_out;

  env_scheduler #(.NUM_BANDS(NB), .WIDTH(W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_valid_in (sample_valid_in),
    .band_samples_in (band_samples_in),
    .filt_valid_out  (filt_valid_out),
    .filt_band_out   (filt_band_out),
    .filt_sample_out (filt_sample_out),
    .filt_ready_in   (filt_ready_in),
    .filt_done_in    (filt_done_in),
    .filt_sample_in  (filt_sample_in),
    .env_out         (env_out),
    .env_valid_out   (env_valid_out),
    .busy_out        (busy_out),
    .overrun_out     (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [TOT-1:0] ins;
    logic [TOT-1:0] exp_env;
    string          tag;
  } frame_vec_t;

  frame_vec_t vecs[3];
  int   errors = 0;
  int   checks = 0;
  logic model_en;
  logic exp_ov;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TOT-1:0] mk(input int a, input int b, input int c, input int d);
    return {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
  endfunction

  // One clock; the filter model answers one cycle after each accepted request with the same sample.
  task automatic cyc();
    logic         acc;
    logic [W-1:0] accv;
    acc  = filt_valid_out && filt_ready_in;
    accv = filt_sample_out;
    @(posedge clk_in);
    @(negedge clk_in);
    if (model_en) begin
      filt_done_in   = acc;
      filt_sample_in = accv;
    end
  endtask

  task automatic run_frame(input logic [TOT-1:0] ins, input logic [TOT-1:0] exp_env, input string tag);
    sample_valid_in = 1'b1;
    band_samples_in = ins;
    cyc();
    sample_valid_in = 1'b0;
    for (int c = 1; c <= 2*NB + 1; c++) begin
      if (c > 1) cyc();
      if ((c % 2 == 1) && (c < 2*NB + 1)) begin
        check({tag, "_valid"}, TOT'(filt_valid_out), TOT'(1));
        check({tag, "_band"}, TOT'(filt_band_out), TOT'((c - 1) / 2));
        check({tag, "_sample"}, TOT'(filt_sample_out), TOT'(exp_env[((c - 1) / 2)*W +: W]));
      end else begin
        check({tag, "_valid_low"}, TOT'(filt_valid_out), TOT'(0));
      end
      check({tag, "_env_valid"}, TOT'(env_valid_out), TOT'(c == 2*NB + 1));
    end
    check({tag, "_env"}, env_out, exp_env);
    cyc();
    check({tag, "_idle_busy"}, TOT'(busy_out), TOT'(0));
  endtask

  task automatic wait_env(input int budget, output int seen);
    seen = -1;
    for (int i = 1; i <= budget; i++) begin
      cyc();
      if (env_valid_out) begin
        seen = i;
        break;
      end
    end
  endtask

  initial begin
    int ev_first, ev_count, seen;
    logic stable_ok;

    vecs[0] = '{mk(100, -200, 300, -400), mk(100, 200, 300, 400), "basic"};
    vecs[1] = '{mk(-8388608, 8388607, 0, -1), mk(8388607, 8388607, 0, 1), "extremes"};
    vecs[2] = '{mk(-5, 7, -123456, 42), mk(5, 7, 123456, 42), "mixed"};

    rst_in = 1'b1; sample_valid_in = 1'b0; band_samples_in = '0;
    filt_ready_in = 1'b1; filt_done_in = 1'b0; filt_sample_in = '0; model_en = 1'b1;
    @(negedge clk_in);
    repeat (3) cyc();
    check("rst_env", env_out, '0);
    check("rst_busy", TOT'(busy_out), TOT'(0));
    check("rst_valid", TOT'(filt_valid_out), TOT'(0));
    check("rst_env_valid", TOT'(env_valid_out), TOT'(0));
    check("rst_overrun", TOT'(overrun_out), TOT'(0));
    rst_in = 1'b0;
    cyc();

    for (int v = 0; v < 3; v++) run_frame(vecs[v].ins, vecs[v].exp_env, vecs[v].tag);

    // Ready withheld for 5 cycles while band 1 is offered.
    sample_valid_in = 1'b1; band_samples_in = vecs[0].ins;
    cyc();
    sample_valid_in = 1'b0;
    ev_first = -1; ev_count = 0; stable_ok = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) cyc();
      if (c >= 3 && c <= 8)
        stable_ok &= filt_valid_out && (filt_band_out == 2'd1) && (filt_sample_out == W'(200));
      if (env_valid_out) begin
        ev_count++;
        if (ev_first < 0) ev_first = c;
      end
      filt_ready_in = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
    end
    check("stall_stable", TOT'(stable_ok), TOT'(1));
    check("stall_env_valid_cycle", TOT'(ev_first), TOT'(14));
    check("stall_env_valid_count", TOT'(ev_count), TOT'(1));
    check("stall_env", env_out, vecs[0].exp_env);

    // Strobes in cycle 3 and in DONE are dropped.
    sample_valid_in = 1'b1; band_samples_in = vecs[2].ins;
    cyc();
    sample_valid_in = 1'b0;
    ev_first = -1;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) cyc();
      sample_valid_in = 1'b0;
      if (env_valid_out && ev_first < 0) ev_first = c;
      if (c == 10 || c == 11) check("drop_idle_busy", TOT'(busy_out), TOT'(0));
      if (c == 3 || c == 9) begin
        sample_valid_in = 1'b1;
        band_samples_in = vecs[0].ins;
      end
    end
    check("drop_env_valid_cycle", TOT'(ev_first), TOT'(9));
    check("drop_env", env_out, vecs[2].exp_env);
`ifdef ENV_SCHEDULER_OVERRUN_EN
    exp_ov = 1'b1;
`else
    exp_ov = 1'b0;
`endif
    check("drop_overrun", TOT'(overrun_out), TOT'(exp_ov));

    // Reset in cycle 4 aborts the frame.
    sample_valid_in = 1'b1; band_samples_in = vecs[1].ins;
    cyc();
    sample_valid_in = 1'b0;
    repeat (3) cyc();
    rst_in = 1'b1;
    cyc();
    check("abort_env", env_out, '0);
    check("abort_busy", TOT'(busy_out), TOT'(0));
    check("abort_env_valid", TOT'(env_valid_out), TOT'(0));
    check("abort_valid", TOT'(filt_valid_out), TOT'(0));
    check("abort_overrun", TOT'(overrun_out), TOT'(0));
    rst_in = 1'b0;
    ev_count = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (env_valid_out || busy_out) ev_count++;
    end
    check("abort_quiet", TOT'(ev_count), TOT'(0));
    run_frame(vecs[0].ins, vecs[0].exp_env, "fresh");

    // Spurious done pulses in IDLE, ISSUE and on the acceptance cycle.
    model_en = 1'b0;
    filt_done_in = 1'b1; filt_sample_in = W'(24'h0ABCDE);
    cyc();
    filt_done_in = 1'b0;
    check("spur_idle_env", env_out, vecs[0].exp_env);
    check("spur_idle_busy", TOT'(busy_out), TOT'(0));
    filt_ready_in = 1'b0;
    sample_valid_in = 1'b1; band_samples_in = vecs[2].ins;
    cyc();
    sample_valid_in = 1'b0;
    filt_done_in = 1'b1; filt_sample_in = W'(24'h000111);
    cyc();
    check("spur_issue_env", env_out, vecs[0].exp_env);
    check("spur_issue_band", TOT'(filt_band_out), TOT'(0));
    check("spur_issue_valid", TOT'(filt_valid_out), TOT'(1));
    filt_ready_in = 1'b1; filt_sample_in = W'(24'h000222);
    cyc();
    check("spur_accept_env", env_out, vecs[0].exp_env);
    check("spur_accept_band", TOT'(filt_band_out), TOT'(0));
    check("spur_accept_valid", TOT'(filt_valid_out), TOT'(0));
    filt_done_in = 1'b1; filt_sample_in = W'(777);
    cyc();
    filt_done_in = 1'b0;
    check("spur_band0_env", env_out, mk(777, 200, 300, 400));
    check("spur_next_band", TOT'(filt_band_out), TOT'(1));
    model_en = 1'b1;
    wait_env(20, seen);
    check("spur_env_valid_seen", TOT'(seen > 0), TOT'(1));
    check("spur_final_env", env_out, mk(777, 7, 123456, 42));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
